// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader and the weight memories it feeds.
// Memory geometry defaults live here so the loader and the ROM/RAM side agree.
package weight_loader_pkg;

  localparam int ADDRESSWIDTH_DEFAULT = 10;
  localparam int DATAWIDTH_DEFAULT    = 16;
  localparam int NUMNEURON_DEFAULT    = 30;
  localparam int NEURONWIDTH_DEFAULT  = 5;
  localparam int LAYERWIDTH_DEFAULT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } loader_state_t;

endpackage

// File: rtl/onehot_decoder.sv
// Binary neuron index to one-hot select, flagging indices past the last neuron.
// Out-of-range indices produce an all-zero select so nothing can be written by them.
module onehot_decoder #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 30
) (
  input  logic [IN_W-1:0]  idx,
  output logic [OUT_W-1:0] onehot,
  output logic             out_of_range
);

  logic [31:0] idx_ext;

  assign idx_ext      = {{(32 - IN_W){1'b0}}, idx};
  assign out_of_range = (idx_ext >= 32'(OUT_W));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = (idx_ext == 32'(i));
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Runtime weight reload: takes a (layer, neuron, count) command, then streams
// count words into the selected neuron's weight memory at addresses 0..count-1.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEFAULT,
  parameter int DATAWIDTH    = DATAWIDTH_DEFAULT,
  parameter int NUMNEURON    = NUMNEURON_DEFAULT,
  parameter int NEURONWIDTH  = NEURONWIDTH_DEFAULT,
  parameter int LAYERWIDTH   = LAYERWIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [LAYERWIDTH-1:0]   cfg_layer,
  input  logic [NEURONWIDTH-1:0]  cfg_neuron,
  input  logic [ADDRESSWIDTH:0]   cfg_count,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATAWIDTH-1:0]    w_data,
  output logic                    wen,
  output logic [ADDRESSWIDTH-1:0] wadd,
  output logic [DATAWIDTH-1:0]    win,
  output logic [NUMNEURON-1:0]    wsel,
  output logic [LAYERWIDTH-1:0]   wlayer,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // Counter is one bit wider than the address so a full-depth load cannot wrap.
  localparam logic [ADDRESSWIDTH:0] MAX_COUNT = {1'b1, {ADDRESSWIDTH{1'b0}}};
  localparam logic [ADDRESSWIDTH:0] ONE       = (ADDRESSWIDTH + 1)'(1);

  loader_state_t state, next_state;

  logic [ADDRESSWIDTH:0] counter;
  logic [ADDRESSWIDTH:0] count_reg;
  logic [NUMNEURON-1:0]  sel_decoded;
  logic                  neuron_bad;
  logic                  cmd_take;
  logic                  cmd_bad;
  logic                  cmd_ok;
  logic                  word_take;
  logic                  last_word;

  onehot_decoder #(
    .IN_W (NEURONWIDTH),
    .OUT_W(NUMNEURON)
  ) u_decoder (
    .idx         (cfg_neuron),
    .onehot      (sel_decoded),
    .out_of_range(neuron_bad)
  );

  assign cfg_ready = (state == ST_IDLE);
  assign w_ready   = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD) || (state == ST_DRAIN);

  assign cmd_take  = cfg_valid && cfg_ready;
  assign cmd_bad   = (cfg_count == '0) || (cfg_count > MAX_COUNT) || neuron_bad;
  assign cmd_ok    = cmd_take && !cmd_bad;
  assign word_take = w_valid && w_ready;
  assign last_word = (counter == (count_reg - ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_ok) begin
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (word_take && last_word) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // The final write and done land together in the DRAIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen       <= 1'b0;
      wadd      <= '0;
      win       <= '0;
      wsel      <= '0;
      wlayer    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      counter   <= '0;
      count_reg <= '0;
    end else begin
      wen  <= 1'b0;
      done <= 1'b0;
      err  <= cmd_take && cmd_bad;
      if (cmd_ok) begin
        wsel      <= sel_decoded;
        wlayer    <= cfg_layer;
        count_reg <= cfg_count;
        counter   <= '0;
      end
      if (word_take) begin
        wen     <= 1'b1;
        wadd    <= counter[ADDRESSWIDTH-1:0];
        win     <= w_data;
        counter <= counter + ONE;
        done    <= last_word;
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader: normal, bubbly, rejected,
// full-depth, reset-aborted and command-during-load scenarios.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_layer;
  logic [4:0]  cfg_neuron;
  logic [10:0] cfg_count;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        wen;
  logic [9:0]  wadd;
  logic [15:0] win;
  logic [29:0] wsel;
  logic [1:0]  wlayer;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [9:0]  wadd_q[$];
  logic [15:0] win_q[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          writes_at_done = -1;

  weight_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_layer (cfg_layer),
    .cfg_neuron(cfg_neuron),
    .cfg_count (cfg_count),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .wen       (wen),
    .wadd      (wadd),
    .win       (win),
    .wsel      (wsel),
    .wlayer    (wlayer),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Log every write and pulse between clock edges.
  always @(negedge clk) begin
    if (wen) begin
      wadd_q.push_back(wadd);
      win_q.push_back(win);
    end
    if (done) begin
      done_cnt++;
      writes_at_done = wadd_q.size();
    end
    if (err) err_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    wadd_q.delete();
    win_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    writes_at_done = -1;
  endtask

  task automatic sendCfg(input logic [1:0] layer, input logic [4:0] neuron, input logic [10:0] count);
    cfg_valid  = 1'b1;
    cfg_layer  = layer;
    cfg_neuron = neuron;
    cfg_count  = count;
    tick();
    cfg_valid  = 1'b0;
  endtask

  // Streams n words (seed + 0x11*(k+1)), optionally idling every other cycle, until done.
  task automatic applyStimulus(input int n, input bit bubbles, input logic [15:0] seed);
    int  sent = 0;
    int  cyc = 0;
    int  done0 = done_cnt;
    bit  acc;
    while (done_cnt == done0 && cyc < n * 3 + 20) begin
      w_valid = (sent < n) && (!bubbles || (cyc % 2 == 0));
      w_data  = seed + 16'(17 * (sent + 1));
      acc     = w_valid && w_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    w_valid = 1'b0;
    checkOutput("stream_done_seen", 32'(done_cnt - done0), 32'd1);
  endtask

  task automatic checkWrites(input string tag, input int n, input logic [15:0] seed);
    int bad = 0;
    checkOutput({tag, "_write_count"}, 32'(wadd_q.size()), 32'(n));
    for (int k = 0; k < wadd_q.size() && k < n; k++) begin
      if (wadd_q[k] !== 10'(k)) bad++;
      if (win_q[k] !== seed + 16'(17 * (k + 1))) bad++;
    end
    checkOutput({tag, "_bad_writes"}, 32'(bad), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_layer  = '0;
    cfg_neuron = '0;
    cfg_count  = '0;
    w_valid    = 1'b0;
    w_data     = '0;
    tick();
    tick();

    checkOutput("reset_wen", 32'(wen), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_wadd", 32'(wadd), 32'd0);
    checkOutput("reset_wsel", 32'(wsel), 32'd0);
    checkOutput("reset_wlayer", 32'(wlayer), 32'd0);
    checkOutput("reset_w_ready", 32'(w_ready), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    $display("[TB] basic load neuron 3, 4 words");
    clearLog();
    sendCfg(2'd1, 5'd3, 11'd4);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_w_ready", 32'(w_ready), 32'd1);
    checkOutput("load_cfg_ready", 32'(cfg_ready), 32'd0);
    checkOutput("load_wsel", 32'(wsel), 32'h0000_0008);
    checkOutput("load_wlayer", 32'(wlayer), 32'd1);
    checkOutput("load_no_wen_yet", 32'(wen), 32'd0);
    w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = 16'(17 * (i + 1));
      tick();
      checkOutput("b2b_wen", 32'(wen), 32'd1);
      checkOutput("b2b_wadd", 32'(wadd), 32'(i));
      checkOutput("b2b_win", 32'(win), 32'(17 * (i + 1)));
      checkOutput("b2b_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
    end
    w_valid = 1'b0;
    checkOutput("drain_busy", 32'(busy), 32'd1);
    checkOutput("drain_w_ready", 32'(w_ready), 32'd0);
    checkOutput("drain_cfg_ready", 32'(cfg_ready), 32'd0);
    tick();
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_done", 32'(done), 32'd0);
    checkOutput("post_wen", 32'(wen), 32'd0);
    checkOutput("post_cfg_ready", 32'(cfg_ready), 32'd1);
    checkOutput("post_wsel_held", 32'(wsel), 32'h0000_0008);
    checkOutput("basic_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] bubbly load neuron 3, 4 words");
    clearLog();
    sendCfg(2'd1, 5'd3, 11'd4);
    applyStimulus(4, 1'b1, 16'h0000);
    checkWrites("bubble", 4, 16'h0000);
    checkOutput("bubble_done_on_last_write", 32'(writes_at_done), 32'd4);
    tick();

    $display("[TB] rejected commands");
    clearLog();
    for (int r = 0; r < 3; r++) begin
      case (r)
        0: sendCfg(2'd0, 5'd3, 11'd0);
        1: sendCfg(2'd0, 5'd3, 11'd1025);
        default: sendCfg(2'd0, 5'd30, 11'd4);
      endcase
      checkOutput("reject_err", 32'(err), 32'd1);
      checkOutput("reject_cfg_ready", 32'(cfg_ready), 32'd1);
      checkOutput("reject_busy", 32'(busy), 32'd0);
      tick();
      checkOutput("reject_err_clear", 32'(err), 32'd0);
    end
    checkOutput("reject_err_pulses", 32'(err_cnt), 32'd3);
    checkOutput("reject_no_writes", 32'(wadd_q.size()), 32'd0);
    checkOutput("reject_wsel_held", 32'(wsel), 32'h0000_0008);

    $display("[TB] full-depth load neuron 29, 1024 words");
    clearLog();
    sendCfg(2'd2, 5'd29, 11'd1024);
    checkOutput("full_wsel", 32'(wsel), 32'h2000_0000);
    applyStimulus(1024, 1'b0, 16'hA500);
    tick();
    checkWrites("full", 1024, 16'hA500);
    checkOutput("full_last_wadd", 32'(wadd_q[$]), 32'd1023);
    checkOutput("full_done_count", 32'(done_cnt), 32'd1);
    checkOutput("full_idle", 32'(busy), 32'd0);

    $display("[TB] reset during load");
    clearLog();
    sendCfg(2'd0, 5'd5, 11'd8);
    w_valid = 1'b1;
    w_data  = 16'h1234;
    tick();
    tick();
    w_valid = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("abort_wen", 32'(wen), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_w_ready", 32'(w_ready), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("abort_no_done_pulse", 32'(done_cnt), 32'd0);
    checkOutput("abort_writes_kept", 32'(wadd_q.size()), 32'd2);
    clearLog();
    sendCfg(2'd0, 5'd7, 11'd2);
    applyStimulus(2, 1'b0, 16'h0100);
    checkWrites("reload", 2, 16'h0100);
    checkOutput("reload_wsel", 32'(wsel), 32'h0000_0080);
    tick();

    $display("[TB] command while loading");
    clearLog();
    sendCfg(2'd3, 5'd10, 11'd3);
    cfg_valid  = 1'b1;
    cfg_neuron = 5'd20;
    cfg_layer  = 2'd0;
    cfg_count  = 11'd5;
    w_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_data = 16'(17 * (i + 1));
      if (i == 2) cfg_valid = 1'b1;
      tick();
      checkOutput("busycmd_err", 32'(err), 32'd0);
      checkOutput("busycmd_wsel", 32'(wsel), 32'h0000_0400);
      checkOutput("busycmd_wlayer", 32'(wlayer), 32'd3);
    end
    checkOutput("busycmd_done", 32'(done), 32'd1);
    cfg_valid = 1'b0;
    w_valid   = 1'b0;
    tick();
    checkOutput("busycmd_idle", 32'(cfg_ready), 32'd1);
    checkOutput("busycmd_err_pulses", 32'(err_cnt), 32'd0);
    checkWrites("busycmd", 3, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
